// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the operands and start; the slave returns the status and the result.
interface serial_subtractor_if #(
  parameter int unsigned W = 4
) ();
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         B_in;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         QB;

  modport master (
    output start, A, B, B_in,
    input  busy, done, D, QB
  );

  modport slave (
    input  start, A, B, B_in,
    output busy, done, D, QB
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: one difference bit per clock, LSB first, with a registered borrow.
// The parallel result and final borrow are held from the done pulse until the next accepted start.
module serial_subtractor #(
  parameter int unsigned W = 4
) (
  input logic               clk,
  input logic               reset,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state;
  logic [W-1:0]   op_a, op_b, res, res_next;
  logic           br, br_next;
  logic           a, b, d;
  logic [CntW-1:0] cnt;
  logic           last;

  // Full-subtractor slice on the current LSBs; the new bit enters the result at the MSB.
  always_comb begin
    a            = op_a[0];
    b            = op_b[0];
    d            = a ^ b ^ br;
    br_next      = (~a & b) | (~(a ^ b) & br);
    res_next     = res >> 1;
    res_next[W-1] = d;
    last         = (cnt == CntW'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.D    <= '0;
      bus.QB   <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_a     <= bus.A;
            op_b     <= bus.B;
            br       <= bus.B_in;
            cnt      <= '0;
            res      <= '0;
            bus.busy <= 1'b1;
            state    <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          res  <= res_next;
          br   <= br_next;
          cnt  <= cnt + CntW'(1);
          if (last) begin
            bus.D    <= res_next;
            bus.QB   <= br_next;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at W=4 (directed) and W=8 (randomized),
// with a scoreboard queue of expected results.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.W(4)) bus4 ();
  serial_subtractor_if #(.W(8)) bus8 ();

  serial_subtractor #(.W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  serial_subtractor #(.W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct packed {
    logic [7:0] d;
    logic       qb;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    exp_t e;
    logic [3:0] diff;
    diff = a - b - {3'b0, bin};
    e.d  = {4'b0, diff};
    e.qb = ({1'b0, a} < ({1'b0, b} + {4'b0, bin}));
    return e;
  endfunction

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    e.d  = a - b - {7'b0, bin};
    e.qb = ({1'b0, a} < ({1'b0, b} + {8'b0, bin}));
    return e;
  endfunction

  // Issue one W=4 operation, optionally pulsing start mid-run, and check result and timing.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                      input bit poke, input string name);
    exp_t e;
    int   n;
    sb4.push_back(model4(a, b, bin));
    bus4.A = a; bus4.B = b; bus4.B_in = bin; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    n = 0;
    while (bus4.busy && n < 20) begin
      if (poke && n == 1) begin
        bus4.A = ~a; bus4.B = ~b; bus4.B_in = ~bin; bus4.start = 1'b1;
      end else begin
        bus4.start = 1'b0;
      end
      n++;
      tick();
    end
    bus4.start = 1'b0;
    n_cmp++;
    if (n !== 4) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d expected 4", name, n);
    end
    n_cmp++;
    if (bus4.done !== 1'b1) begin
      n_fail++; $display("FAIL %s done: got %b expected 1", name, bus4.done);
    end
    e = sb4.pop_front();
    n_cmp++;
    if (bus4.D !== e.d[3:0]) begin
      n_fail++; $display("FAIL %s D: got %0d expected %0d", name, bus4.D, e.d[3:0]);
    end
    n_cmp++;
    if (bus4.QB !== e.qb) begin
      n_fail++; $display("FAIL %s QB: got %b expected %b", name, bus4.QB, e.qb);
    end
    tick();
    tick();
    n_cmp++;
    if (bus4.done !== 1'b0 || bus4.busy !== 1'b0 || bus4.D !== e.d[3:0] || bus4.QB !== e.qb) begin
      n_fail++;
      $display("FAIL %s hold: got done=%b busy=%b D=%0d QB=%b expected done=0 busy=0 D=%0d QB=%b",
               name, bus4.done, bus4.busy, bus4.D, bus4.QB, e.d[3:0], e.qb);
    end
  endtask

  task automatic test_reset();
    bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.B_in = 1'b0;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.B_in = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({bus4.busy, bus4.done, bus4.D, bus4.QB} !== 7'b0) begin
      n_fail++; $display("FAIL reset_w4: got busy=%b done=%b D=%0d QB=%b expected all 0",
                         bus4.busy, bus4.done, bus4.D, bus4.QB);
    end
    n_cmp++;
    if ({bus8.busy, bus8.done, bus8.D, bus8.QB} !== 11'b0) begin
      n_fail++; $display("FAIL reset_w8: got busy=%b done=%b D=%0d QB=%b expected all 0",
                         bus8.busy, bus8.done, bus8.D, bus8.QB);
    end
  endtask

  task automatic test_directed();
    run4(4'd9,  4'd3,  1'b0, 1'b0, "9-3");
    run4(4'd3,  4'd9,  1'b0, 1'b0, "3-9");
    run4(4'd0,  4'd0,  1'b1, 1'b0, "0-0-1");
    run4(4'd15, 4'd15, 1'b0, 1'b0, "15-15");
    run4(4'd7,  4'd2,  1'b1, 1'b0, "7-2-1");
  endtask

  task automatic test_start_ignored();
    run4(4'd12, 4'd5, 1'b0, 1'b1, "start_mid_run");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    sb4.push_back(model4(4'd8, 4'd1, 1'b0));
    sb4.push_back(model4(4'd5, 4'd7, 1'b0));
    bus4.A = 4'd8; bus4.B = 4'd1; bus4.B_in = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.A = 4'd5; bus4.B = 4'd7;
    n = 0;
    while (!bus4.done && n < 20) begin n++; tick(); end
    n_cmp++;
    if (n !== 4) begin
      n_fail++; $display("FAIL b2b_first_latency: got %0d expected 4", n);
    end
    e = sb4.pop_front();
    n_cmp++;
    if (bus4.D !== e.d[3:0] || bus4.QB !== e.qb || bus4.busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first: got D=%0d QB=%b busy=%b expected D=%0d QB=%b busy=0",
                         bus4.D, bus4.QB, bus4.busy, e.d[3:0], e.qb);
    end
    tick();
    n_cmp++;
    if (bus4.busy !== 1'b1 || bus4.done !== 1'b0 || bus4.D !== e.d[3:0]) begin
      n_fail++; $display("FAIL b2b_restart: got busy=%b done=%b D=%0d expected busy=1 done=0 D=%0d",
                         bus4.busy, bus4.done, bus4.D, e.d[3:0]);
    end
    bus4.start = 1'b0;
    n = 1;
    while (!bus4.done && n < 20) begin n++; tick(); end
    n_cmp++;
    if (n !== 5) begin
      n_fail++; $display("FAIL b2b_done_spacing: got %0d expected 5", n);
    end
    e = sb4.pop_front();
    n_cmp++;
    if (bus4.D !== e.d[3:0] || bus4.QB !== e.qb) begin
      n_fail++; $display("FAIL b2b_second: got D=%0d QB=%b expected D=%0d QB=%b",
                         bus4.D, bus4.QB, e.d[3:0], e.qb);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int seen;
    bus4.A = 4'd9; bus4.B = 4'd3; bus4.B_in = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({bus4.busy, bus4.done, bus4.D, bus4.QB} !== 7'b0) begin
      n_fail++; $display("FAIL reset_mid_run: got busy=%b done=%b D=%0d QB=%b expected all 0",
                         bus4.busy, bus4.done, bus4.D, bus4.QB);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus4.done || bus4.busy) seen++;
      tick();
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_no_done: got %0d active cycles expected 0", seen);
    end
    run4(4'd10, 4'd4, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    exp_t e;
    logic [7:0] a, b;
    logic bin;
    int n;
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      if (k % 50 == 0) begin a = 8'h00; b = 8'hFF; end
      if (k % 50 == 1) begin a = 8'hFF; b = 8'hFF; bin = 1'b1; end
      sb8.push_back(model8(a, b, bin));
      bus8.A = a; bus8.B = b; bus8.B_in = bin; bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      n = 0;
      while (!bus8.done && n < 30) begin n++; tick(); end
      n_cmp++;
      if (n !== 8) begin
        n_fail++; $display("FAIL rand%0d latency: got %0d expected 8", k, n);
      end
      e = sb8.pop_front();
      n_cmp++;
      if (bus8.D !== e.d || bus8.QB !== e.qb) begin
        n_fail++; $display("FAIL rand%0d result: got D=%0d QB=%b expected D=%0d QB=%b",
                           k, bus8.D, bus8.QB, e.d, e.qb);
      end
      tick();
      n_cmp++;
      if (bus8.done !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d done_width: got %b expected 0", k, bus8.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
